// File: rtl/bp_pkg.sv
// Shared types, counter encodings and helpers for the branch-predictor controller.
package bp_pkg;

    localparam int unsigned CWIDTH = 2;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned ADDR_W = PC_W - 2;

    localparam logic [CWIDTH-1:0] SNT = 2'b00;
    localparam logic [CWIDTH-1:0] WNT = 2'b01;
    localparam logic [CWIDTH-1:0] WT  = 2'b10;
    localparam logic [CWIDTH-1:0] ST  = 2'b11;

    // Effective cache read after write-port forwarding.
    typedef struct packed {
        logic              hit;
        logic [CWIDTH-1:0] data;
    } bp_eff_t;

    function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] c);
        return (&c) ? c : c + CWIDTH'(1);
    endfunction

    function automatic logic [CWIDTH-1:0] sat_dec(input logic [CWIDTH-1:0] c);
        return (c == '0) ? c : c - CWIDTH'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] pc_to_addr(input logic [PC_W-1:0] pc);
        return pc[PC_W-1:2];
    endfunction

endpackage

// File: rtl/bp_track_pipe.sv
// Shift register carrying each issued guess {valid, taken, addr} to the check stage.
module bp_track_pipe #(
    parameter int unsigned AWIDTH = 30,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_taken,
    input  logic [AWIDTH-1:0] in_addr,
    output logic              out_valid,
    output logic              out_taken,
    output logic [AWIDTH-1:0] out_addr
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  taken_q, taken_d;
    logic [AWIDTH-1:0] addr_q [DEPTH];
    logic [AWIDTH-1:0] addr_d [DEPTH];

    always_comb begin
        valid_d = valid_q;
        taken_d = taken_q;
        addr_d  = addr_q;
        if (!stall) begin
            valid_d[0] = in_valid;
            taken_d[0] = in_taken;
            addr_d[0]  = in_addr;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_d[i] = valid_q[i-1];
                taken_d[i] = taken_q[i-1];
                addr_d[i]  = addr_q[i-1];
            end
        end
        // Flush wins over stall so a frozen pipe can still be emptied.
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            taken_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            taken_q <= taken_d;
            addr_q  <= addr_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_taken = taken_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/bp_ctrl.sv
// Branch-predictor controller: fetch-side lookup, execute-side 2-bit counter update with
// forwarding, guess tracking, mispredict flag and branch statistics.
module bp_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned AWIDTH      = PC_WIDTH - 2,
    parameter int unsigned TRACK_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                guess_valid,
    input  logic [PC_WIDTH-1:0] guess_pc,
    output logic                guess_taken,
    input  logic                check_valid,
    input  logic [PC_WIDTH-1:0] check_pc,
    input  logic                check_taken,
    output logic                mispredict,
    output logic [31:0]         br_count,
    output logic [31:0]         mispred_count,
    output logic [AWIDTH-1:0]   bpc_ra0,
    input  logic [CWIDTH-1:0]   bpc_dout0,
    input  logic                bpc_hit0,
    output logic [AWIDTH-1:0]   bpc_ra1,
    input  logic [CWIDTH-1:0]   bpc_dout1,
    input  logic                bpc_hit1,
    output logic [AWIDTH-1:0]   bpc_wa,
    output logic [CWIDTH-1:0]   bpc_din,
    output logic                bpc_we
);

    logic              bpc_we_q, bpc_we_d;
    logic [AWIDTH-1:0] bpc_wa_q, bpc_wa_d;
    logic [CWIDTH-1:0] bpc_din_q, bpc_din_d;
    logic              mispredict_q, mispredict_d;
    logic [31:0]       br_count_q, br_count_d;
    logic [31:0]       mispred_count_q, mispred_count_d;

    bp_eff_t           eff0, eff1;
    logic              upd_fire;
    logic [CWIDTH-1:0] new_ctr;
    logic              old_valid, old_taken;
    logic [AWIDTH-1:0] old_addr;
    logic              unused_pc_lsbs;

    assign bpc_ra0        = guess_pc[PC_WIDTH-1:2];
    assign bpc_ra1        = check_pc[PC_WIDTH-1:2];
    assign unused_pc_lsbs = ^{guess_pc[1:0], check_pc[1:0]};

    bp_track_pipe #(
        .AWIDTH (AWIDTH),
        .DEPTH  (TRACK_DEPTH)
    ) u_track (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (guess_valid),
        .in_taken  (guess_taken),
        .in_addr   (bpc_ra0),
        .out_valid (old_valid),
        .out_taken (old_taken),
        .out_addr  (old_addr)
    );

    // The write in flight this cycle has not reached the cache yet, so both read ports see it here.
    always_comb begin
        eff0 = '{hit: bpc_hit0, data: bpc_dout0};
        eff1 = '{hit: bpc_hit1, data: bpc_dout1};
        if (bpc_we_q && (bpc_wa_q == bpc_ra0)) begin
            eff0 = '{hit: 1'b1, data: bpc_din_q};
        end
        if (bpc_we_q && (bpc_wa_q == bpc_ra1)) begin
            eff1 = '{hit: 1'b1, data: bpc_din_q};
        end
        guess_taken = guess_valid && eff0.hit && eff0.data[CWIDTH-1];
    end

    always_comb begin
        upd_fire = check_valid && !stall;
        if (eff1.hit) begin
            new_ctr = check_taken ? sat_inc(eff1.data) : sat_dec(eff1.data);
        end else begin
            new_ctr = check_taken ? WT : WNT;
        end

        bpc_we_d        = upd_fire;
        bpc_wa_d        = upd_fire ? bpc_ra1 : bpc_wa_q;
        bpc_din_d       = upd_fire ? new_ctr : bpc_din_q;
        mispredict_d    = upd_fire && old_valid && (old_taken != check_taken);
        br_count_d      = upd_fire ? br_count_q + 32'd1 : br_count_q;
        mispred_count_d = mispredict_d ? mispred_count_q + 32'd1 : mispred_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bpc_we_q        <= 1'b0;
            bpc_wa_q        <= '0;
            bpc_din_q       <= '0;
            mispredict_q    <= 1'b0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            bpc_we_q        <= bpc_we_d;
            bpc_wa_q        <= bpc_wa_d;
            bpc_din_q       <= bpc_din_d;
            mispredict_q    <= mispredict_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign bpc_we        = bpc_we_q;
    assign bpc_wa        = bpc_wa_q;
    assign bpc_din       = bpc_din_q;
    assign mispredict    = mispredict_q;
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

    // A resolved branch must belong to the guess at the head of the tracking pipe.
    track_addr_match: assert property (@(posedge clk) disable iff (reset)
        (upd_fire && old_valid) |-> (old_addr == bpc_ra1))
        else $error("bp_ctrl: tracked addr %0h differs from check addr %0h", old_addr, bpc_ra1);

endmodule

// File: tb/tb_bp_ctrl.sv
// Directed table-driven bench for bp_ctrl with a small tagged behavioural bp_cache.
module tb_bp_ctrl;
    import bp_pkg::*;

    logic        clk, reset, stall, flush;
    logic        guess_valid, guess_taken, check_valid, check_taken, mispredict;
    logic [31:0] guess_pc, check_pc, br_count, mispred_count;
    logic [29:0] bpc_ra0, bpc_ra1, bpc_wa;
    logic [1:0]  bpc_dout0, bpc_dout1, bpc_din;
    logic        bpc_hit0, bpc_hit1, bpc_we;

    int total = 0;
    int bad   = 0;

    bp_ctrl u_dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .guess_valid   (guess_valid),
        .guess_pc      (guess_pc),
        .guess_taken   (guess_taken),
        .check_valid   (check_valid),
        .check_pc      (check_pc),
        .check_taken   (check_taken),
        .mispredict    (mispredict),
        .br_count      (br_count),
        .mispred_count (mispred_count),
        .bpc_ra0       (bpc_ra0),
        .bpc_dout0     (bpc_dout0),
        .bpc_hit0      (bpc_hit0),
        .bpc_ra1       (bpc_ra1),
        .bpc_dout1     (bpc_dout1),
        .bpc_hit1      (bpc_hit1),
        .bpc_wa        (bpc_wa),
        .bpc_din       (bpc_din),
        .bpc_we        (bpc_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tagged cache: index skips addr bit 3 so 0x100 and 0x120 alias to one set.
    logic        c_val [32];
    logic [24:0] c_tag [32];
    logic [1:0]  c_dat [32];

    function automatic logic [4:0] cidx(input logic [29:0] a);
        return {a[7:6], a[2:0]};
    endfunction

    function automatic logic [24:0] ctag(input logic [29:0] a);
        return {a[29:8], a[5:3]};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                c_val[i] <= 1'b0;
                c_tag[i] <= '0;
                c_dat[i] <= '0;
            end
        end else if (bpc_we) begin
            c_val[cidx(bpc_wa)] <= 1'b1;
            c_tag[cidx(bpc_wa)] <= ctag(bpc_wa);
            c_dat[cidx(bpc_wa)] <= bpc_din;
        end
    end

    always_comb begin
        bpc_hit0  = c_val[cidx(bpc_ra0)] && (c_tag[cidx(bpc_ra0)] == ctag(bpc_ra0));
        bpc_dout0 = c_dat[cidx(bpc_ra0)];
        bpc_hit1  = c_val[cidx(bpc_ra1)] && (c_tag[cidx(bpc_ra1)] == ctag(bpc_ra1));
        bpc_dout1 = c_dat[cidx(bpc_ra1)];
    end

    typedef struct {
        logic        stall, flush, gv;
        logic [31:0] gpc;
        logic        cv;
        logic [31:0] cpc;
        logic        ct;
        logic        e_gt, e_we;
        logic [29:0] e_wa;
        logic [1:0]  e_din;
        logic        e_mp;
        logic [31:0] e_br, e_mis;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic f, input logic gv,
                                input logic [31:0] gpc, input logic cv, input logic [31:0] cpc,
                                input logic ct, input logic e_gt, input logic e_we,
                                input logic [31:0] e_wpc, input logic [1:0] e_din,
                                input logic e_mp, input int e_br, input int e_mis);
        vec_t v;
        v.stall = s;  v.flush = f;  v.gv = gv;  v.gpc = gpc;
        v.cv = cv;    v.cpc = cpc;  v.ct = ct;
        v.e_gt = e_gt; v.e_we = e_we; v.e_wa = pc_to_addr(e_wpc); v.e_din = e_din;
        v.e_mp = e_mp; v.e_br = 32'(e_br); v.e_mis = 32'(e_mis);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs applied #1 after a posedge; guess_taken sampled before the edge, registers after it.
    task automatic run_vec(input vec_t v, input string tag);
        stall = v.stall;  flush = v.flush;
        guess_valid = v.gv;  guess_pc = v.gpc;
        check_valid = v.cv;  check_pc = v.cpc;  check_taken = v.ct;
        #1;
        chk({tag, " guess_taken"}, 32'(guess_taken), 32'(v.e_gt));
        @(posedge clk);
        #1;
        chk({tag, " bpc_we"}, 32'(bpc_we), 32'(v.e_we));
        if (v.e_we) begin
            chk({tag, " bpc_wa"}, 32'(bpc_wa), 32'(v.e_wa));
            chk({tag, " bpc_din"}, 32'(bpc_din), 32'(v.e_din));
        end
        chk({tag, " mispredict"}, 32'(mispredict), 32'(v.e_mp));
        chk({tag, " br_count"}, br_count, v.e_br);
        chk({tag, " mispred_count"}, mispred_count, v.e_mis);
    endtask

    vec_t tab [28];
    vec_t seq [14];

    initial begin
        //             s f gv gpc     cv cpc     ct gt we wpc     din mp br  mis
        tab[0]  = mk(0,0,1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0,  0);
        tab[1]  = mk(0,0,0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0,  0);
        tab[2]  = mk(0,0,0, 32'h0,   1, 32'h100, 1, 0, 1, 32'h100, 2, 1, 1,  1);
        tab[3]  = mk(0,0,1, 32'h100, 0, 32'h0,   0, 1, 0, 32'h0,   0, 0, 1,  1);
        tab[4]  = mk(0,0,1, 32'h100, 0, 32'h0,   0, 1, 0, 32'h0,   0, 0, 1,  1);
        tab[5]  = mk(0,0,0, 32'h0,   1, 32'h100, 1, 0, 1, 32'h100, 3, 0, 2,  1);
        tab[6]  = mk(0,0,0, 32'h0,   1, 32'h100, 0, 0, 1, 32'h100, 2, 1, 3,  2);
        tab[7]  = mk(0,0,0, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 3,  2);
        tab[8]  = mk(0,0,0, 32'h0,   1, 32'h200, 1, 0, 1, 32'h200, 2, 0, 4,  2);
        tab[9]  = mk(0,0,0, 32'h0,   1, 32'h200, 1, 0, 1, 32'h200, 3, 0, 5,  2);
        tab[10] = mk(0,0,0, 32'h0,   1, 32'h200, 1, 0, 1, 32'h200, 3, 0, 6,  2);
        tab[11] = mk(0,0,0, 32'h0,   1, 32'h200, 1, 0, 1, 32'h200, 3, 0, 7,  2);
        tab[12] = mk(0,0,0, 32'h0,   1, 32'h200, 0, 0, 1, 32'h200, 2, 0, 8,  2);
        tab[13] = mk(0,0,0, 32'h0,   1, 32'h200, 0, 0, 1, 32'h200, 1, 0, 9,  2);
        tab[14] = mk(0,0,0, 32'h0,   1, 32'h200, 0, 0, 1, 32'h200, 0, 0, 10, 2);
        tab[15] = mk(0,0,0, 32'h0,   1, 32'h200, 0, 0, 1, 32'h200, 0, 0, 11, 2);
        tab[16] = mk(0,0,0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 11, 2);
        tab[17] = mk(0,0,0, 32'h0,   1, 32'h300, 0, 0, 1, 32'h300, 1, 0, 12, 2);
        tab[18] = mk(0,0,0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 12, 2);
        tab[19] = mk(0,0,0, 32'h0,   1, 32'h300, 1, 0, 1, 32'h300, 2, 0, 13, 2);
        tab[20] = mk(0,0,0, 32'h0,   1, 32'h300, 1, 0, 1, 32'h300, 3, 0, 14, 2);
        tab[21] = mk(0,0,0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 14, 2);
        tab[22] = mk(0,0,0, 32'h0,   1, 32'h100, 1, 0, 1, 32'h100, 3, 0, 15, 2);
        tab[23] = mk(0,0,0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 15, 2);
        tab[24] = mk(0,0,1, 32'h120, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 15, 2);
        tab[25] = mk(0,0,1, 32'h100, 0, 32'h0,   0, 1, 0, 32'h0,   0, 0, 15, 2);
        tab[26] = mk(0,0,0, 32'h0,   1, 32'h120, 0, 0, 1, 32'h120, 1, 0, 16, 2);
        tab[27] = mk(0,0,0, 32'h0,   1, 32'h100, 1, 0, 1, 32'h100, 3, 0, 17, 2);

        // Post-reset sequence: train, mispredict, flush-kill, stall-hold.
        seq[0]  = mk(0,0,1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0,  0);
        seq[1]  = mk(0,0,0, 32'h0,   1, 32'h100, 1, 0, 1, 32'h100, 2, 0, 1,  0);
        seq[2]  = mk(0,0,0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 1,  0);
        seq[3]  = mk(0,0,1, 32'h100, 0, 32'h0,   0, 1, 0, 32'h0,   0, 0, 1,  0);
        seq[4]  = mk(0,0,0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 1,  0);
        seq[5]  = mk(0,0,0, 32'h0,   1, 32'h100, 0, 0, 1, 32'h100, 1, 1, 2,  1);
        seq[6]  = mk(0,0,0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 2,  1);
        seq[7]  = mk(0,0,1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 2,  1);
        seq[8]  = mk(0,1,0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 2,  1);
        seq[9]  = mk(0,0,0, 32'h0,   1, 32'h100, 1, 0, 1, 32'h100, 2, 0, 3,  1);
        seq[10] = mk(0,0,1, 32'h100, 0, 32'h0,   0, 1, 0, 32'h0,   0, 0, 3,  1);
        seq[11] = mk(0,0,0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 3,  1);
        seq[12] = mk(1,0,0, 32'h0,   1, 32'h100, 0, 0, 0, 32'h0,   0, 0, 3,  1);
        seq[13] = mk(0,0,0, 32'h0,   1, 32'h100, 0, 0, 1, 32'h100, 1, 1, 4,  2);

        reset = 1'b1;  stall = 1'b0;  flush = 1'b0;
        guess_valid = 1'b0;  guess_pc = 32'h100;
        check_valid = 1'b0;  check_pc = 32'h0;  check_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset bpc_we", 32'(bpc_we), 32'h0);
        chk("reset bpc_wa", 32'(bpc_wa), 32'h0);
        chk("reset bpc_din", 32'(bpc_din), 32'h0);
        chk("reset mispredict", 32'(mispredict), 32'h0);
        chk("reset br_count", br_count, 32'h0);
        chk("reset mispred_count", mispred_count, 32'h0);
        chk("reset guess_taken", 32'(guess_taken), 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 28; i++) begin
            run_vec(tab[i], $sformatf("v%0d", i));
        end

        // Reset while a write is pending: write dropped, stats cleared.
        run_vec(mk(0,0,0, 32'h0, 1, 32'h100, 1, 0, 1, 32'h100, 3, 0, 18, 2), "pre_reset");
        reset = 1'b1;
        run_vec(mk(0,0,0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0), "mid_reset");
        chk("mid_reset bpc_wa", 32'(bpc_wa), 32'h0);
        chk("mid_reset bpc_din", 32'(bpc_din), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_vec(seq[i], $sformatf("s%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
